// File: rtl/instr_fetch_arbiter.sv
// instr_fetch_arbiter
//   Shares one combinational instruction-memory read port between two fetch
//   requesters. One grant per cycle, round-robin between the two requesters.
//   The granted requester's instruction comes back registered one cycle later.
//   Each requester has a saturating count of its error-free fetches.
//
// Ports
//   clk_i               system clock, rising edge
//   rst_i               asynchronous reset, active low
//   req0_i / req1_i     fetch requests
//   addr0_i / addr1_i   byte addresses, held stable until granted
//   gnt0_o / gnt1_o     combinational grants
//   vld0_o / vld1_o     registered instruction-valid pulses
//   instr0_o / instr1_o registered instructions (zero on address error)
//   err0_o / err1_o     registered address-error flags, qualified by vldX_o
//   mem_addr_o          byte address to the instruction memory (0 when idle)
//   mem_instr_i         memory data, combinational from mem_addr_o
//   cnt0_o / cnt1_o     saturating error-free grant counters
//
// Priority pointer states
//   state | meaning
//   P0    | requester 0 wins when both request
//   P1    | requester 1 wins when both request

module instr_fetch_arbiter #(
    parameter int MEM_DEPTH = 32,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic [31:0]      addr0_i,
    output logic             gnt0_o,
    output logic             vld0_o,
    output logic [31:0]      instr0_o,
    output logic             err0_o,
    input  logic             req1_i,
    input  logic [31:0]      addr1_i,
    output logic             gnt1_o,
    output logic             vld1_o,
    output logic [31:0]      instr1_o,
    output logic             err1_o,
    output logic [31:0]      mem_addr_o,
    input  logic [31:0]      mem_instr_i,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } prio_t;

    localparam logic [29:0]      DEPTH_WORDS = 30'(MEM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    prio_t       prio_q;
    prio_t       prio_d;
    logic        err_sel;
    logic [31:0] instr_sel;

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_WORDS);
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prio_q <= P0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        gnt0_o     = 1'b0;
        gnt1_o     = 1'b0;
        prio_d     = prio_q;
        mem_addr_o = 32'h0;

        if (req0_i && (!req1_i || prio_q == P0)) begin
            gnt0_o = 1'b1;
        end else if (req1_i) begin
            gnt1_o = 1'b1;
        end

        // The pointer always ends up naming the requester that lost this cycle.
        if (gnt0_o) begin
            prio_d     = P1;
            mem_addr_o = addr0_i;
        end else if (gnt1_o) begin
            prio_d     = P0;
            mem_addr_o = addr1_i;
        end
    end

    // Only meaningful while a grant is active; mem_addr_o carries the winner's address.
    assign err_sel   = bad_addr(mem_addr_o);
    assign instr_sel = err_sel ? 32'h0 : mem_instr_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld0_o   <= 1'b0;
            vld1_o   <= 1'b0;
            err0_o   <= 1'b0;
            err1_o   <= 1'b0;
            instr0_o <= 32'h0;
            instr1_o <= 32'h0;
            cnt0_o   <= '0;
            cnt1_o   <= '0;
        end else begin
            vld0_o <= gnt0_o;
            vld1_o <= gnt1_o;
            if (gnt0_o) begin
                instr0_o <= instr_sel;
                err0_o   <= err_sel;
                if (!err_sel && cnt0_o != CNT_MAX) begin
                    cnt0_o <= cnt0_o + CNT_ONE;
                end
            end
            if (gnt1_o) begin
                instr1_o <= instr_sel;
                err1_o   <= err_sel;
                if (!err_sel && cnt1_o != CNT_MAX) begin
                    cnt1_o <= cnt1_o + CNT_ONE;
                end
            end
        end
    end

endmodule
